// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 UART transmitter with parameterised bit period
module uart_tx_8n1 #(
    parameter int BAUD = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       tx
);

    localparam int LP_CW = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(BAUD - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [9:0]        r_frame;
    logic [LP_CW-1:0]  r_baud_cnt;
    logic [3:0]        r_bit_cnt;
    logic              r_ready;
    logic              w_accept;
    logic              w_wrap;
    logic              w_done;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_wrap       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_baud_cnt == LP_LAST) begin
                    w_wrap = 1'b1;
                    if (r_bit_cnt == 4'd9) begin
                        w_done       = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // The line is driven straight from frame bit 0; ones shifted in keep it idle-high afterwards.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_frame    <= '1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_ready    <= 1'b1;
        end else if (w_accept) begin
            r_frame    <= {1'b1, data, 1'b0};
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_ready    <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            if (w_wrap) begin
                r_frame    <= {1'b1, r_frame[9:1]};
                r_baud_cnt <= '0;
                r_bit_cnt  <= w_done ? 4'd0 : r_bit_cnt + 4'd1;
                r_ready    <= w_done;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
        end
    end

    assign tx    = r_frame[0];
    assign ready = r_ready;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb/tb_uart_tx_8n1.sv - directed bench for uart_tx_8n1 at BAUD=4 and default BAUD
module tb_uart_tx_8n1;

    logic       clk;
    logic       rstn;
    logic [7:0] data4;
    logic       start4;
    logic       ready4;
    logic       tx4;
    logic [7:0] data_d;
    logic       start_d;
    logic       ready_d;
    logic       tx_d;

    int n_vec;
    int n_err;

    uart_tx_8n1 #(.BAUD(4)) dut4 (
        .clk   (clk),
        .rstn  (rstn),
        .data  (data4),
        .start (start4),
        .ready (ready4),
        .tx    (tx4)
    );

    uart_tx_8n1 dut_d (
        .clk   (clk),
        .rstn  (rstn),
        .data  (data_d),
        .start (start_d),
        .ready (ready_d),
        .tx    (tx_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s_tx%0d", tag, i), tx4, 1);
            check($sformatf("%s_rdy%0d", tag, i), ready4, 1);
        end
    endtask

    // exp is the hand-written frame, bit 0 sent first; each bit is sampled on all 4 of its cycles.
    task automatic frame_check(input string tag, input logic [7:0] d, input logic [9:0] exp,
                               input logic mut, input logic busy);
        @(negedge clk);
        data4  = d;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("%s_tx%0d", tag, k), tx4, exp[k/4]);
            if (k % 4 == 0) check($sformatf("%s_busy%0d", tag, k), ready4, 0);
            if (mut && k == 1) data4 = 8'h00;
            if (busy && k == 9) start4 = 1'b1;
            if (busy && k == 10) start4 = 1'b0;
        end
        idle_check({tag, "_end"}, 8);
    endtask

    initial begin
        logic [9:0] f55;
        logic [9:0] f0d;
        int         k;
        n_vec   = 0;
        n_err   = 0;
        rstn    = 1'b1;
        data4   = 8'h00;
        start4  = 1'b0;
        data_d  = 8'h00;
        start_d = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_tx", tx4, 1);
        check("rst_rdy", ready4, 1);
        start4 = 1'b1;
        @(negedge clk);
        check("rst_start_tx", tx4, 1);
        check("rst_start_rdy", ready4, 1);
        start4 = 1'b0;
        rstn   = 1'b0;
        idle_check("post_rst", 3);

        frame_check("a5", 8'hA5, 10'b1_1010_0101_0, 1'b0, 1'b0);
        frame_check("latch", 8'h5A, 10'b1_0101_1010_0, 1'b1, 1'b0);
        frame_check("ignore", 8'h5A, 10'b1_0101_1010_0, 1'b0, 1'b1);

        // Abandon a frame of zeros mid data bit; reset must force the line high without a clock edge.
        @(negedge clk);
        data4  = 8'h00;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_tx_low", tx4, 0);
        #2 rstn = 1'b1;
        #1;
        check("mid_rst_tx", tx4, 1);
        check("mid_rst_rdy", ready4, 1);
        @(negedge clk);
        rstn = 1'b0;
        idle_check("mid_rel", 45);

        f55 = 10'b1_0101_0101_0;
        @(negedge clk);
        data4  = 8'h55;
        start4 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 41; j++) begin
                @(negedge clk);
                if (j < 40) begin
                    check($sformatf("cont%0d_tx%0d", f, j), tx4, f55[j/4]);
                    if (j % 4 == 0) check($sformatf("cont%0d_busy%0d", f, j), ready4, 0);
                end else begin
                    check($sformatf("cont%0d_gap_tx", f), tx4, 1);
                    check($sformatf("cont%0d_gap_rdy", f), ready4, 1);
                    if (f == 2) start4 = 1'b0;
                end
            end
        end
        idle_check("cont_end", 5);

        f0d = 10'b1_0000_1101_0;
        @(negedge clk);
        data_d  = 8'h0D;
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        k = 0;
        while (ready_d == 1'b0 && k < 5000) begin
            if (k % 434 == 0 || k % 434 == 433)
                check($sformatf("def_tx%0d", k), tx_d, f0d[k/434]);
            @(negedge clk);
            k++;
        end
        check("def_len", k, 4340);
        check("def_idle_tx", tx_d, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
